ps2_move_decoder: RTL and testbench

- Upstream input stage for the snake processor. Receives raw PS/2 keyboard clock and data and decodes them into the per-player movement words that the processor samples as `move1` and `move2`.
- Player 1 uses the arrow keys. Player 2 uses W/A/S/D.
- Direction encoding is 0=up, 1=right, 2=down, 3=left.
- A request to turn directly back on the current direction is rejected in hardware.

---
 rtl/ps2_move_decoder_if.sv | 38 +++
 rtl/ps2_move_decoder.sv | 215 +++++++++++++++++++++
 tb/tb_ps2_move_decoder.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/ps2_move_decoder_if.sv
// Bundles the PS/2 line inputs and the decoded outputs of ps2_move_decoder.
//   ps2_clock   raw PS/2 clock from the keyboard (asynchronous to the system clock)
//   ps2_data    raw PS/2 data (asynchronous to the system clock)
//   move1       player-1 direction, {30'b0, dir}
//   move2       player-2 direction, {30'b0, dir}
//   key_valid   one-cycle pulse per completed make code
//   scan_code   last completed make code, held between pulses
//   frame_error one-cycle pulse on parity, stop-bit or timeout error
// master: keyboard/consumer side. slave: the decoder.
interface ps2_move_decoder_if;
    logic        ps2_clock;
    logic        ps2_data;
    logic [31:0] move1;
    logic [31:0] move2;
    logic        key_valid;
    logic [7:0]  scan_code;
    logic        frame_error;

    modport master (
        output ps2_clock,
        output ps2_data,
        input  move1,
        input  move2,
        input  key_valid,
        input  scan_code,
        input  frame_error
    );

    modport slave (
        input  ps2_clock,
        input  ps2_data,
        output move1,
        output move2,
        output key_valid,
        output scan_code,
        output frame_error
    );
endinterface

// File: rtl/ps2_move_decoder.sv
// PS/2 keyboard receiver that turns key presses into per-player movement words.
// Player 1 steers with the arrow keys (E0-prefixed), player 2 with W/A/S/D.
// Direction encoding: 0=up, 1=right, 2=down, 3=left. A turn straight back onto
// the current heading is dropped.
// Ports:
//   clock  system clock
//   reset  asynchronous, active-high reset
//   ps2    slave side of ps2_move_decoder_if (raw PS/2 lines in, decoded results out)
module ps2_move_decoder #(
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic                clock,
    input  logic                reset,
    ps2_move_decoder_if.slave   ps2
);

    localparam int unsigned Stages = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam int unsigned TmoW   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

    // ------------------------------------------------------------------
    // Input synchronisation and falling-edge detect
    // ------------------------------------------------------------------
    logic [Stages-1:0] clk_sync_q;
    logic [Stages-1:0] dat_sync_q;
    logic              clk_prev_q;
    logic              fe_q;
    logic              dat_q;   // synced data captured alongside fe_q

    logic clk_cur;
    logic dat_cur;
    assign clk_cur = clk_sync_q[Stages-1];
    assign dat_cur = dat_sync_q[Stages-1];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            // Lines idle high, so reset to 1 to avoid a false edge after reset
            clk_sync_q <= '1;
            dat_sync_q <= '1;
            clk_prev_q <= 1'b1;
            fe_q       <= 1'b0;
            dat_q      <= 1'b1;
        end else begin
            clk_sync_q <= {clk_sync_q[Stages-2:0], ps2.ps2_clock};
            dat_sync_q <= {dat_sync_q[Stages-2:0], ps2.ps2_data};
            clk_prev_q <= clk_cur;
            fe_q       <= clk_prev_q & ~clk_cur;
            dat_q      <= dat_cur;
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM: start, 8 data bits LSB first, odd parity, stop
    // ------------------------------------------------------------------
    state_e          state_q;
    logic [2:0]      bit_cnt_q;
    logic [7:0]      shift_q;
    logic            parity_q;
    logic [TmoW-1:0] tmo_cnt_q;
    logic            byte_strobe_q;
    logic [7:0]      byte_q;
    logic            frame_error_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            bit_cnt_q     <= 3'd0;
            shift_q       <= 8'h00;
            parity_q      <= 1'b0;
            tmo_cnt_q     <= '0;
            byte_strobe_q <= 1'b0;
            byte_q        <= 8'h00;
            frame_error_q <= 1'b0;
        end else begin
            byte_strobe_q <= 1'b0;
            frame_error_q <= 1'b0;
            // An edge takes priority over a timeout landing in the same cycle
            if (fe_q) begin
                tmo_cnt_q <= '0;
                unique case (state_q)
                    StIdle: begin
                        if (!dat_q) begin
                            state_q   <= StData;
                            bit_cnt_q <= 3'd0;
                        end
                    end
                    StData: begin
                        shift_q <= {dat_q, shift_q[7:1]};
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= StParity;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                        end
                    end
                    StParity: begin
                        parity_q <= dat_q;
                        state_q  <= StStop;
                    end
                    StStop: begin
                        state_q <= StIdle;
                        if (dat_q && (^{shift_q, parity_q})) begin
                            byte_strobe_q <= 1'b1;
                            byte_q        <= shift_q;
                        end else begin
                            frame_error_q <= 1'b1;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end else if (state_q == StIdle) begin
                tmo_cnt_q <= '0;
            end else if (tmo_cnt_q == TmoLast) begin
                state_q       <= StIdle;
                frame_error_q <= 1'b1;
                tmo_cnt_q     <= '0;
            end else begin
                tmo_cnt_q <= tmo_cnt_q + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Byte interpreter: break/extended prefixes, make-code lookup
    // ------------------------------------------------------------------
    logic       brk_q, brk_d;
    logic       ext_q, ext_d;
    logic       key_valid_q, key_valid_d;
    logic [7:0] scan_code_q, scan_code_d;
    logic [1:0] dir1_q, dir1_d;
    logic [1:0] dir2_q, dir2_d;

    logic       map_hit;
    logic [1:0] map_dir;

    // ext selects the arrow-key table (player 1), otherwise WASD (player 2)
    always_comb begin
        map_hit = 1'b1;
        map_dir = 2'd0;
        if (ext_q) begin
            unique case (byte_q)
                8'h75:   map_dir = 2'd0;
                8'h74:   map_dir = 2'd1;
                8'h72:   map_dir = 2'd2;
                8'h6B:   map_dir = 2'd3;
                default: map_hit = 1'b0;
            endcase
        end else begin
            unique case (byte_q)
                8'h1D:   map_dir = 2'd0;
                8'h23:   map_dir = 2'd1;
                8'h1B:   map_dir = 2'd2;
                8'h1C:   map_dir = 2'd3;
                default: map_hit = 1'b0;
            endcase
        end
    end

    always_comb begin
        brk_d       = brk_q;
        ext_d       = ext_q;
        key_valid_d = 1'b0;
        scan_code_d = scan_code_q;
        dir1_d      = dir1_q;
        dir2_d      = dir2_q;
        if (byte_strobe_q) begin
            if (byte_q == 8'hF0) begin
                brk_d = 1'b1;
            end else if (byte_q == 8'hE0) begin
                ext_d = 1'b1;
            end else begin
                brk_d = 1'b0;
                ext_d = 1'b0;
                if (!brk_q) begin
                    key_valid_d = 1'b1;
                    scan_code_d = byte_q;
                    // Reversal reject: opposite heading is dir XOR 2
                    if (map_hit && ext_q && (map_dir != (dir1_q ^ 2'd2))) begin
                        dir1_d = map_dir;
                    end
                    if (map_hit && !ext_q && (map_dir != (dir2_q ^ 2'd2))) begin
                        dir2_d = map_dir;
                    end
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            brk_q       <= 1'b0;
            ext_q       <= 1'b0;
            key_valid_q <= 1'b0;
            scan_code_q <= 8'h00;
            dir1_q      <= 2'd1;
            dir2_q      <= 2'd3;
        end else begin
            brk_q       <= brk_d;
            ext_q       <= ext_d;
            key_valid_q <= key_valid_d;
            scan_code_q <= scan_code_d;
            dir1_q      <= dir1_d;
            dir2_q      <= dir2_d;
        end
    end

    assign ps2.move1       = {30'b0, dir1_q};
    assign ps2.move2       = {30'b0, dir2_q};
    assign ps2.key_valid   = key_valid_q;
    assign ps2.scan_code   = scan_code_q;
    assign ps2.frame_error = frame_error_q;

endmodule

// File: tb/tb_ps2_move_decoder.sv
// Directed bench for ps2_move_decoder. Expected key/error events are queued as
// frames are sent and matched by a monitor whenever the DUT pulses an output.
module tb_ps2_move_decoder;

    localparam int unsigned Tmo  = 2000;
    localparam int unsigned Half = 20;   // PS/2 half-period in system clocks

    logic clock;
    logic reset;
    ps2_move_decoder_if bus ();

    ps2_move_decoder #(
        .TIMEOUT_CYCLES (Tmo),
        .SYNC_STAGES    (2)
    ) dut (
        .clock (clock),
        .reset (reset),
        .ps2   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic       err;
        logic [7:0] code;
        logic [1:0] m1;
        logic [1:0] m2;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_key(input logic [7:0] code, input logic [1:0] m1, input logic [1:0] m2);
        exp_t e;
        e.err = 1'b0; e.code = code; e.m1 = m1; e.m2 = m2;
        sb.push_back(e);
    endtask

    task automatic push_err();
        exp_t e;
        e.err = 1'b1; e.code = 8'h00; e.m1 = 2'd0; e.m2 = 2'd0;
        sb.push_back(e);
    endtask

    // Sends the first nbits of a frame; lat enables a cycle-exact check on the stop edge
    task automatic send_frame(input logic [7:0] b, input bit flip_par, input logic stop,
                              input int nbits, input bit lat);
        logic [10:0] bits;
        bits = {stop, (~^b) ^ flip_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            bus.ps2_data = bits[i];
            repeat (Half) @(negedge clock);
            bus.ps2_clock = 1'b0;
            if (lat && i == 10) begin
                repeat (4) @(posedge clock);
                #1 check("lat_early_kv", 32'(bus.key_valid), 32'd0);
                @(posedge clock);
                #1;
                check("lat_kv", 32'(bus.key_valid), 32'd1);
                check("lat_scan", 32'(bus.scan_code), 32'h72);
                check("lat_move1", bus.move1, 32'd2);
                repeat (Half - 5) @(negedge clock);
            end else begin
                repeat (Half) @(negedge clock);
            end
            if (i < 10) bus.ps2_clock = 1'b1;
        end
        bus.ps2_clock = 1'b1;
        bus.ps2_data  = 1'b1;
        repeat (2 * Half) @(negedge clock);
    endtask

    task automatic send(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b1, 11, 1'b0);
    endtask

    // Monitor: every pulse must match the next queued event
    always @(negedge clock) begin
        if (!reset && (bus.key_valid || bus.frame_error)) begin
            if (sb.size() == 0) begin
                check("unexpected_kv", 32'(bus.key_valid), 32'd0);
                check("unexpected_fe", 32'(bus.frame_error), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("ev_fe", 32'(bus.frame_error), 32'(e.err));
                check("ev_kv", 32'(bus.key_valid), 32'(!e.err));
                if (!e.err) begin
                    check("ev_scan", 32'(bus.scan_code), 32'(e.code));
                    check("ev_move1", bus.move1, 32'(e.m1));
                    check("ev_move2", bus.move2, 32'(e.m2));
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset         = 1'b1;
        bus.ps2_clock = 1'b1;
        bus.ps2_data  = 1'b1;
        repeat (5) @(negedge clock);
        reset = 1'b0;
        repeat (100) @(negedge clock);
        check("rst_move1", bus.move1, 32'd1);
        check("rst_move2", bus.move2, 32'd3);
        check("rst_kv", 32'(bus.key_valid), 32'd0);
        check("rst_fe", 32'(bus.frame_error), 32'd0);
        check("rst_scan", 32'(bus.scan_code), 32'h00);

        // Player 1 down, with exact latency from the stop edge
        send(8'hE0);
        push_key(8'h72, 2'd2, 2'd3);
        send_frame(8'h72, 1'b0, 1'b1, 11, 1'b1);
        // Release: no pulse
        send(8'hE0); send(8'hF0); send(8'h72);
        check("release_quiet", 32'(sb.size()), 32'd0);
        check("release_move1", bus.move1, 32'd2);

        // Player 1 reversal rules
        push_key(8'h75, 2'd2, 2'd3); send(8'hE0); send(8'h75);
        push_key(8'h6B, 2'd3, 2'd3); send(8'hE0); send(8'h6B);
        push_key(8'h74, 2'd3, 2'd3); send(8'hE0); send(8'h74);

        // Player 2
        push_key(8'h1D, 2'd3, 2'd0); send(8'h1D);
        push_key(8'h1B, 2'd3, 2'd0); send(8'h1B);
        push_key(8'h23, 2'd3, 2'd1); send(8'h23);

        // Bad parity, then bad stop bit
        push_err(); send_frame(8'h1D, 1'b1, 1'b1, 11, 1'b0);
        push_err(); send_frame(8'h1C, 1'b0, 1'b0, 11, 1'b0);
        check("err_move1", bus.move1, 32'd3);
        check("err_move2", bus.move2, 32'd1);
        check("err_scan", 32'(bus.scan_code), 32'h23);

        // Timeout after start + 4 data bits
        push_err();
        send_frame(8'h1D, 1'b0, 1'b1, 5, 1'b0);
        repeat (Tmo + 100) @(negedge clock);
        check("tmo_fired", 32'(sb.size()), 32'd0);
        push_key(8'h6B, 2'd3, 2'd1); send(8'hE0); send(8'h6B);

        // Reset in the middle of a frame
        bus.ps2_data = 1'b0;
        repeat (Half) @(negedge clock);
        bus.ps2_clock = 1'b0;
        repeat (Half) @(negedge clock);
        bus.ps2_clock = 1'b1;
        bus.ps2_data  = 1'b1;
        repeat (Half) @(negedge clock);
        bus.ps2_clock = 1'b0;
        repeat (Half / 2) @(negedge clock);
        reset = 1'b1;
        #1;
        check("mid_rst_move1", bus.move1, 32'd1);
        check("mid_rst_move2", bus.move2, 32'd3);
        check("mid_rst_kv", 32'(bus.key_valid), 32'd0);
        check("mid_rst_fe", 32'(bus.frame_error), 32'd0);
        check("mid_rst_scan", 32'(bus.scan_code), 32'h00);
        repeat (3) @(negedge clock);
        bus.ps2_clock = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (50) @(negedge clock);

        // Fresh byte after the aborted frame
        push_key(8'h1D, 2'd1, 2'd0); send(8'h1D);
        repeat (50) @(negedge clock);
        check("sb_drain", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
